gemm32_acc_drain: RTL and testbench
===================================

# gemm32_acc_drain

Downstream stage of the 32-lane GEMM dot-product datapath. Consumes the unsigned 18-bit dot-product `sum` produced each cycle by the multiplier/adder-tree array and accumulates TILES consecutive partial sums, one per K-tile, into one wide result. Presents each result through a one-entry valid/ready output register, so accumulation of the next result overlaps with downstream backpressure.

## Interface
Parameters:
- `IN_W`, 18: width of incoming partial sum.
- `ACC_W`, 32: accumulator and output width; must be ≥ IN_W.
- `TILES`, 4: partial sums per result; range 1..65535.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `clear`  in  1: synchronous discard of the partial accumulation in progress.
- `in_valid`  in  1: `in_sum` valid.
- `in_ready`  out  1: stage accepts `in_sum` this cycle.
- `in_sum`  in  IN_W: unsigned partial sum.
- `out_valid`  out  1: `out_data` holds a completed result.
- `out_ready`  in  1: downstream accepts `out_data`.
- `out_data`  out  ACC_W: completed accumulation.
- `ovf`  out  1: sticky; set when any accumulation exceeded 2^ACC_W − 1.
- `tile_idx`  out  16: index (0..TILES−1) of the next beat to be accepted.

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- State is the beat counter `tile_idx`, plus `out_valid`:
  - ACCUM (`tile_idx` < TILES−1): accept sets acc ← (`tile_idx`==0 ? in_sum : acc + in_sum), then `tile_idx`++.
  - LAST (`tile_idx` == TILES−1): accept loads `out_data` ← acc + in_sum (in_sum alone if TILES==1), sets `out_valid`=1, `tile_idx` ← 0.
- `in_ready` = !rst && !clear && !(tile_idx==TILES−1 && out_valid && !out_ready). This is combinational from `out_ready`.
- Output drain: `out_valid && out_ready` with no LAST accept clears `out_valid`.
- Simultaneous drain and LAST accept: `out_data` is reloaded with the new result and `out_valid` stays 1. No bubble.
- `clear`: `tile_idx` ← 0 and acc ← 0. `out_data`, `out_valid` and `ovf` are unaffected. Clear has priority over an input beat, and `in_ready` is 0 that cycle.
- Arithmetic is unsigned. in_sum is zero-extended to ACC_W+1 bits and added, and the carry bit is the overflow detect. Overflow handling depends on the macro (see Configuration). Any detected carry sets `ovf`, which is cleared only by `rst`.
- `rst` mid-operation discards the partial and pending results immediately.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `ovf`=0, `tile_idx`=0, acc=0. `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: `out_valid` rises in the cycle after the LAST beat is accepted.
- Throughput: one beat per cycle, sustained indefinitely when `out_ready` is held at 1.
- Stall: only the LAST beat stalls, and only while a previous result is undrained.
- `out_data` and `out_valid` are registered. `out_data` is held stable while `out_valid && !out_ready`.

## Configuration
- `GEMM_ACC_SAT_EN` defined: on carry out, acc and `out_data` clamp to 2^ACC_W − 1. Further additions within the same result stay clamped.
- `GEMM_ACC_SAT_EN` undefined: the sum wraps modulo 2^ACC_W.
- `ovf` is set identically in both builds.

## Test plan
- TILES=4, `out_ready`=1, inputs 100, 200, 300, 400 on consecutive cycles -> `out_valid` one cycle after the 400 beat, `out_data`=1000, `tile_idx` back to 0.
- Back-to-back: 8 beats of 18'h3FFFF -> two results of 1048572, with `in_valid`/`in_ready` high every cycle.
- Backpressure: first result pending with `out_ready`=0 -> `in_ready` drops at the LAST beat of the second result. Raising `out_ready` drains 1000, the stalled beat is accepted that same cycle, and `out_valid` remains 1 with the second value.
- ACC_W=20, TILES=8, eight beats of 262143 -> with `GEMM_ACC_SAT_EN`, `out_data`=1048575 and `ovf`=1. Without it, `out_data`=1048568 and `ovf`=1.
- `clear` after 2 of 4 beats (values 5, 7), then beats 1, 2, 3, 4 -> `out_data`=10. A pending result is unchanged by `clear`.
- `rst` pulsed asynchronously mid-cycle with `out_valid`=1 and `tile_idx`=2 -> all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gemm32_acc_drain.sv
// gemm32_acc_drain: accumulates TILES partial sums per result into a one-entry valid/ready output register; GEMM_ACC_SAT_EN selects saturation over wrap.
module gemm32_acc_drain #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 32,
  parameter int TILES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic [15:0]      tile_idx
);
  localparam logic [15:0] LAST = 16'(TILES - 1);
  logic [15:0] tile_q, tile_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, res;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, last, accept;
  logic [ACC_W:0] sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tile_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tile_q      <= tile_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  always_comb begin
    last   = tile_q == LAST;
    accept = in_valid && in_ready;
    sum    = {1'b0, (tile_q == 16'd0) ? {ACC_W{1'b0}} : acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
`ifdef GEMM_ACC_SAT_EN
    res = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    res = sum[ACC_W-1:0];
`endif
    tile_d      = clear ? 16'd0 : accept ? (last ? 16'd0 : tile_q + 16'd1) : tile_q;
    acc_d       = clear ? {ACC_W{1'b0}} : (accept && !last) ? res : acc_q;
    out_data_d  = (accept && last) ? res : out_data_q;
    out_valid_d = (accept && last) || (out_valid_q && !out_ready);
    ovf_d       = ovf_q || (accept && sum[ACC_W]);
  end
  // the LAST beat stalls only while the previous result is still undrained
  always_comb begin
    in_ready  = !rst && !clear && !(last && out_valid_q && !out_ready);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    ovf       = ovf_q;
    tile_idx  = tile_q;
  end
endmodule

// File: tb/tb_gemm32_acc_drain.sv
// tb_gemm32_acc_drain: vector table, hand corner sequences and a randomized run against a total-based reference model.
module tb_gemm32_acc_drain;
`ifdef GEMM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [17:0] in_sum = '0;
  logic in_ready, out_valid, ovf;
  logic [31:0] out_data;
  logic [15:0] tile_idx;
  logic clear2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [17:0] in_sum2 = '0;
  logic in_ready2, out_valid2, ovf2;
  logic [19:0] out_data2;
  logic [15:0] tile_idx2;
  int total = 0, bad = 0;

  gemm32_acc_drain dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .tile_idx(tile_idx)
  );

  gemm32_acc_drain #(.IN_W(18), .ACC_W(20), .TILES(8)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sum(in_sum2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .ovf(ovf2), .tile_idx(tile_idx2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [17:0] s;
    logic        r;
    logic        c;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [15:0] e_ti;
  } vec_t;
  vec_t tbl[31];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint part, pdata, mx;
    int cnt;
    bit pend, movf, erdy, produced;
    tbl[0]  = '{1, 100, 1, 0, 1, 0, 0, 1};
    tbl[1]  = '{1, 200, 1, 0, 1, 0, 0, 2};
    tbl[2]  = '{1, 300, 1, 0, 1, 0, 0, 3};
    tbl[3]  = '{1, 400, 1, 0, 1, 1, 1000, 0};
    tbl[4]  = '{0, 0, 1, 0, 1, 0, 1000, 0};
    tbl[5]  = '{1, 18'h3FFFF, 1, 0, 1, 0, 1000, 1};
    tbl[6]  = '{1, 18'h3FFFF, 1, 0, 1, 0, 1000, 2};
    tbl[7]  = '{1, 18'h3FFFF, 1, 0, 1, 0, 1000, 3};
    tbl[8]  = '{1, 18'h3FFFF, 1, 0, 1, 1, 1048572, 0};
    tbl[9]  = '{1, 18'h3FFFF, 1, 0, 1, 0, 1048572, 1};
    tbl[10] = '{1, 18'h3FFFF, 1, 0, 1, 0, 1048572, 2};
    tbl[11] = '{1, 18'h3FFFF, 1, 0, 1, 0, 1048572, 3};
    tbl[12] = '{1, 18'h3FFFF, 1, 0, 1, 1, 1048572, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 1048572, 0};
    tbl[14] = '{1, 100, 0, 0, 1, 0, 1048572, 1};
    tbl[15] = '{1, 200, 0, 0, 1, 0, 1048572, 2};
    tbl[16] = '{1, 300, 0, 0, 1, 0, 1048572, 3};
    tbl[17] = '{1, 400, 0, 0, 1, 1, 1000, 0};
    tbl[18] = '{1, 10, 0, 0, 1, 1, 1000, 1};
    tbl[19] = '{1, 20, 0, 0, 1, 1, 1000, 2};
    tbl[20] = '{1, 30, 0, 0, 1, 1, 1000, 3};
    tbl[21] = '{1, 40, 0, 0, 0, 1, 1000, 3};
    tbl[22] = '{1, 40, 1, 0, 1, 1, 100, 0};
    tbl[23] = '{1, 5, 0, 0, 1, 1, 100, 1};
    tbl[24] = '{1, 7, 0, 0, 1, 1, 100, 2};
    tbl[25] = '{1, 9, 0, 1, 0, 1, 100, 0};
    tbl[26] = '{1, 1, 1, 0, 1, 0, 100, 1};
    tbl[27] = '{1, 2, 1, 0, 1, 0, 100, 2};
    tbl[28] = '{1, 3, 1, 0, 1, 0, 100, 3};
    tbl[29] = '{1, 4, 1, 0, 1, 1, 10, 0};
    tbl[30] = '{0, 0, 1, 0, 1, 0, 10, 0};
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tile_idx", tile_idx, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 31; i++) begin
      in_valid = tbl[i].v; in_sum = tbl[i].s; out_ready = tbl[i].r; clear = tbl[i].c;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("vec%0d_tile_idx", i), tile_idx, tbl[i].e_ti);
    end
    chk("tbl_ovf", ovf, 0);
    in_valid = 1'b0; clear = 1'b0;
    chk("w20_ovf_before", ovf2, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1; in_sum2 = 18'd262143; out_ready2 = 1'b1;
      #1;
      chk($sformatf("w20_in_ready%0d", i), in_ready2, 1);
      step();
    end
    in_valid2 = 1'b0;
    chk("w20_out_valid", out_valid2, 1);
    chk("w20_out_data", out_data2, SAT ? 64'd1048575 : 64'd1048568);
    chk("w20_ovf", ovf2, 1);
    chk("w20_tile_idx", tile_idx2, 0);
    out_ready = 1'b0; in_sum = 18'd1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("arst_pre_out_valid", out_valid, 1);
    chk("arst_pre_tile_idx", tile_idx, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_tile_idx", tile_idx, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_w20_ovf", ovf2, 0);
    step();
    rst = 1'b0;
    part = 0; pdata = 0; cnt = 0; pend = 0; movf = 0;
    mx = (longint'(1) << 32) - 1;
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_sum = 18'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      clear = $urandom_range(0, 15) == 0;
      #1;
      erdy = !clear && !(cnt == 3 && pend && !out_ready);
      chk("rand_in_ready", in_ready, erdy);
      produced = 0;
      if (clear) begin
        cnt = 0; part = 0;
      end else if (in_valid && erdy) begin
        part = (cnt == 0 ? 0 : part) + longint'(in_sum);
        if (part > mx) movf = 1;
        cnt++;
        if (cnt == 4) begin
          pdata = SAT ? (part > mx ? mx : part) : (part & mx);
          pend = 1; produced = 1; cnt = 0;
        end
      end
      if (!produced && pend && out_ready) pend = 0;
      step();
      chk("rand_out_valid", out_valid, pend);
      if (pend) chk("rand_out_data", out_data, pdata);
      chk("rand_tile_idx", tile_idx, cnt);
      chk("rand_ovf", ovf, movf);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
